// File: rtl/dc_restore_filter_if.sv
// Sample-sink handshake for the DC-restore stage: filtered samples in,
// reconstructed samples and saturation pulse out.
interface dc_restore_filter_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] data_in;
  logic                     data_valid;
  logic                     data_ready;
  logic signed [DATA_W-1:0] data_out;
  logic                     data_out_valid;
  logic                     sat_flag;

  modport master (
    output data_in, data_valid,
    input  data_ready, data_out, data_out_valid, sat_flag
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, data_out, data_out_valid, sat_flag
  );
endinterface

// File: rtl/dc_restore_filter.sv
// Inverse of the first-order DC-removal stage: x[n] = x[n-1] + y[n]/alpha - y[n-1],
// with 1/alpha applied by a bit-serial shift-add multiplier and a saturated output.
module dc_restore_filter #(
  parameter int              DATA_W    = 16,
  parameter int              COEF_W    = 16,
  parameter logic [COEF_W-1:0] INV_ALPHA = 16'h4010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  dc_restore_filter_if.slave ifc
);

  localparam int PW    = DATA_W + COEF_W + 1;
  localparam int CW    = (COEF_W > 1) ? $clog2(COEF_W) : 1;
  localparam int SHIFT = COEF_W - 2;
  localparam int HI_I  = 2**(DATA_W-1) - 1;
  localparam logic signed [PW-1:0] SUM_HI = PW'(HI_I);
  localparam logic signed [PW-1:0] SUM_LO = PW'(-HI_I - 1);
  localparam logic [CW-1:0]        LAST   = CW'(COEF_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] x_prev, y_prev, y_cur, out_p1;
  logic signed [PW-1:0]     acc, acc_step, sum;
  logic [CW-1:0]            cnt;
  logic                     accept, coef_bit, vld_p1, sat_p1;

  function automatic logic signed [PW-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(PW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic out_of_range(input logic signed [PW-1:0] v);
    return (v > SUM_HI) || (v < SUM_LO);
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [PW-1:0] v);
    if (v > SUM_HI)      return SUM_HI[DATA_W-1:0];
    else if (v < SUM_LO) return SUM_LO[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  assign ifc.data_ready     = (state_q == IDLE) && !clear;
  assign ifc.data_out       = out_p1;
  assign ifc.data_out_valid = vld_p1;
  assign ifc.sat_flag       = sat_p1;
  assign accept             = ifc.data_valid && ifc.data_ready;

  // MUL: coefficient consumed MSB first, so each step doubles the partial product
  assign coef_bit = INV_ALPHA[LAST - cnt];
  assign acc_step = (acc <<< 1) + (coef_bit ? sext(y_cur) : {PW{1'b0}});

  // ACC: floor-shift the exact product back to sample scale and close the recursion
  assign sum = sext(x_prev) + (acc >>> SHIFT) - sext(y_prev);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL:     if (cnt == LAST) state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x_prev <= '0;
      y_prev <= '0;
      y_cur  <= '0;
      acc    <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
      sat_p1 <= 1'b0;
      if (rst) out_p1 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      sat_p1 <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            y_cur <= ifc.data_in;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        MUL: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        ACC: begin
          out_p1 <= saturate(sum);
          vld_p1 <= 1'b1;
          sat_p1 <= out_of_range(sum);
          x_prev <= saturate(sum);
          y_prev <= y_cur;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_restore_filter.sv
// Directed bench for dc_restore_filter: a reference model of the recursion and
// handshake timing checked every cycle, plus hand-computed expected samples.
module tb_dc_restore_filter;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  dc_restore_filter_if #(.DATA_W(DW)) ifc ();

  dc_restore_filter #(.DATA_W(DW), .COEF_W(16), .INV_ALPHA(16'h4010)) dut (
    .clk(clk), .rst(rst), .clear(clear), .ifc(ifc)
  );

  typedef struct {longint due; int val; bit sat;} exp_t;

  int     n_cmp = 0, n_bad = 0;
  longint ecnt = 0, busy_end = 0;
  int     m_x = 0, m_y = 0, last_out = 0;
  int     acc_cnt = 0, pulse_cnt = 0;
  bit     chk_en = 1'b0;
  exp_t   pend[$];
  int     out_log[$];
  bit     sat_log[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // x[n] = x[n-1] + floor(y*16400/16384) - y[n-1], clamped to 16-bit range
  function automatic int restore_step(input int y, input int xp, input int yp, output bit sat);
    longint s, total;
    s     = floor_div(longint'(y) * 16400, 16384);
    total = longint'(xp) + s - longint'(yp);
    sat   = (total > 32767) || (total < -32768);
    if (total > 32767)  total = 32767;
    if (total < -32768) total = -32768;
    return int'(total);
  endfunction

  // Reference model: observes the bench-driven controls on every rising edge
  initial forever begin
    bit s;
    @(posedge clk);
    ecnt++;
    if (rst) begin
      chk_en = 1'b1; m_x = 0; m_y = 0; last_out = 0;
      pend.delete(); busy_end = ecnt;
    end else if (clear) begin
      m_x = 0; m_y = 0; pend.delete(); busy_end = ecnt;
    end else if (ifc.data_valid && ecnt > busy_end) begin
      m_x = restore_step(int'(ifc.data_in), m_x, m_y, s);
      m_y = int'(ifc.data_in);
      pend.push_back('{due: ecnt + 17, val: m_x, sat: s});
      busy_end = ecnt + 17;
      acc_cnt++;
    end
  end

  // Compare process: outputs sampled on the falling edge
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (chk_en) begin
      if (ifc.data_out_valid) begin
        out_log.push_back(int'(ifc.data_out));
        sat_log.push_back(ifc.sat_flag);
      end
      check("data_ready", ifc.data_ready, !clear && (ecnt >= busy_end));
      if (pend.size() > 0 && pend[0].due == ecnt) begin
        e = pend.pop_front();
        check("pulse_valid", ifc.data_out_valid, 1);
        check("pulse_data", ifc.data_out, e.val);
        check("pulse_sat", ifc.sat_flag, e.sat);
        last_out = e.val;
        pulse_cnt++;
      end else begin
        check("idle_valid", ifc.data_out_valid, 0);
        check("idle_sat", ifc.sat_flag, 0);
        check("hold_data", ifc.data_out, last_out);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    out_log.delete();
    sat_log.delete();
  endtask

  task automatic send(input int y);
    int i;
    for (i = 0; i < 40; i++) begin
      if (ifc.data_ready) break;
      @(posedge clk); #2;
    end
    check("ready_wait", (i < 40), 1);
    ifc.data_in    = DW'(y);
    ifc.data_valid = 1'b1;
    @(posedge clk); #2;
    ifc.data_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 60; i++) begin
      if (out_log.size() >= n) break;
      @(posedge clk); #2;
    end
    check("out_count", out_log.size(), n);
  endtask

  initial begin
    bit s;
    int a0, p0, x, y, hx, hy, v, d;
    ifc.data_in = '0;
    ifc.data_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;

    check("model_1000", restore_step(1000, 0, 0, s), 1000);
    check("model_floor", restore_step(-1000, 0, 0, s), -1001);
    check("model_sat_hi", restore_step(32767, 0, 0, s), 32767);
    check("model_sat_hi_flag", s, 1);

    // Steady 1000 input reconstructs 1000 every time
    send(1000); send(1000); send(1000);
    wait_out(3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) begin
      check("dc_1000_val", out_log[i], 1000);
      check("dc_1000_sat", sat_log[i], 0);
    end

    // Negative product floors toward -inf
    do_reset();
    send(-1000);
    wait_out(1);
    if (out_log.size() > 0) check("neg_floor", out_log[0], -1001);

    // Saturation both ways
    do_reset();
    send(32767); send(-32768);
    wait_out(2);
    if (out_log.size() > 1) begin
      check("sat_hi_val", out_log[0], 32767);
      check("sat_hi_flag", sat_log[0], 1);
      check("sat_lo_val", out_log[1], -32768);
      check("sat_lo_flag", sat_log[1], 1);
    end

    // data_valid held high: one accept per 18 cycles
    do_reset();
    a0 = acc_cnt; p0 = pulse_cnt;
    ifc.data_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ifc.data_in = DW'(i * 37 - 1000);
      @(posedge clk); #2;
    end
    ifc.data_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("stream_accepts", acc_cnt - a0, 5);
    check("stream_pulses", pulse_cnt - p0, 5);

    // clear on the fifth MUL edge aborts the sample and zeroes the history
    do_reset();
    send(1000);
    wait_out(1);
    send(200);
    repeat (4) @(posedge clk);
    #2 clear = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0;
    send(500);
    wait_out(2);
    if (out_log.size() > 1) check("after_clear", out_log[1], 500);

    // rst mid-multiply: no output, data_out back to zero
    send(300);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    out_log.delete(); sat_log.delete();
    repeat (25) @(posedge clk);
    #2;
    check("rst_abort_pulses", out_log.size(), 0);
    check("rst_data_out", ifc.data_out, 0);

    // Loopback: ramp + DC 2000 through a DC-removal filter that rounds its
    // alpha product up, y = ceil(alpha*(y[n-1] + x[n] - x[n-1]))
    do_reset();
    hx = 0; hy = 0;
    for (int n = 0; n < 20; n++) begin
      x  = 2000 + 100 * n;
      v  = hy + x - hx;
      y  = int'((longint'(32736) * v + 32767) / 32768);
      hx = x; hy = y;
      send(y);
      wait_out(n + 1);
      if (out_log.size() > n) begin
        d = out_log[n] - x;
        if (n >= 8) check("loop_track", ((d <= 4) && (d >= -4)), 1);
        check("loop_nosat", sat_log[n], 0);
      end
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dc_restore_filter.md
# dc_restore_filter

Inverse of the first-order DC-removal high-pass stage. It reconstructs an estimate of the original input stream from high-pass-filtered samples using x[n] = x[n-1] + y[n]/alpha - y[n-1]. The 1/alpha product uses a serial shift-add multiplier, and the output is saturated. It sits after the high-pass filter on the calibration/loopback path, where it checks filter integrity and recovers baseline. It is also a data sink with a valid/ready handshake.

## Interface
- data_width, 16: sample width, signed two's complement.
- coeff_width, 16: width of the reciprocal coefficient. Also equals the number of multiply cycles.
- inv_alpha, 16'h4010: 1/alpha as unsigned Q2.14, so 16400/16384 ≈ 1.000977, the inverse of alpha = 0x7FE0 in Q1.15. There are coeff_width-2 fraction bits.

- clk, in, 1: sole clock. Rising edge.
- rst, in, 1: synchronous, active-high reset.
- clear, in, 1: synchronous, active-high flush of state and any in-flight sample.
- data_in, in, data_width: filtered sample y[n], signed.
- data_valid, in, 1: data_in is valid.
- data_ready, out, 1: block can accept a sample. Equals (state == IDLE) && !clear.
- data_out, out, data_width: reconstructed sample x[n], signed, saturated. Registered.
- data_out_valid, out, 1: one-cycle pulse marking a new data_out.
- sat_flag, out, 1: one-cycle pulse, coincident with data_out_valid, when saturation occurred.

## Operation
- State registers:
  - x_prev: last output, data_width bits.
  - y_prev: last accepted input, data_width bits.
  - y_cur: sample being processed.
  - Multiplier accumulator and step counter.
- FSM states are IDLE, MUL and ACC.
- IDLE:
  - A sample is accepted on an edge where data_valid && data_ready.
  - On acceptance, y_cur <= data_in, the accumulator and counter are cleared, and the FSM goes to MUL.
- MUL: exactly coeff_width cycles, one coefficient bit per cycle.
  - Result P = y_cur * inv_alpha is exact and signed, with width data_width+coeff_width+1.
  - The internal method is free (signed shift-add, or magnitude-then-negate), but the cycle count is fixed.
- ACC: one cycle.
  - s = P >>> (coeff_width-2), an arithmetic shift that floors toward -inf.
  - sum = x_prev + s - y_prev, computed in data_width+3 bits with no intermediate overflow.
  - Saturate sum to [-2^(data_width-1), 2^(data_width-1)-1].
  - Register data_out <= sat(sum), data_out_valid <= 1, sat_flag <= (sum out of range).
  - Update x_prev <= sat(sum) and y_prev <= y_cur, then go to IDLE.
- data_valid outside IDLE is ignored. data_ready is low, so no sample is lost or queued.
- clear (any state):
  - x_prev, y_prev, y_cur, accumulator and counter go to 0; FSM goes to IDLE.
  - data_out_valid and sat_flag are 0 next cycle. data_out holds its value.
  - An aborted sample produces no output.
  - clear with data_valid in the same cycle: clear wins, data_ready is low, and the sample is not accepted.
- rst has priority over clear. It has the same effect as clear, plus data_out <= 0.

## Timing
- Values after a reset edge:
  - data_out = 0, data_out_valid = 0, sat_flag = 0.
  - data_ready = 1 (state IDLE).
  - x_prev = y_prev = 0.
- Accept edge E0.
- MUL covers edges E1..E16 (for coeff_width = 16).
- The ACC edge is E17. data_out_valid and sat_flag are high for the single cycle after E17.
- data_ready is low from after E0 until after E17.
- Earliest next accept is E18, giving a throughput of 1 sample per coeff_width+2 cycles.
- data_out is stable between pulses. It changes only on ACC edges or on rst.
- rst or clear asserted during MUL or ACC aborts immediately. There is no partial output.

## Test plan
- Reset, then inputs 1000, 1000, 1000 -> outputs 1000, 1000, 1000. Each data_out_valid pulse comes 17 edges after its accept edge. sat_flag stays 0.
- Reset, then input -1000 -> output -1001, confirming the floor on a negative product (-16400000 >>> 14).
- Reset, then input 32767 -> output 32767 with sat_flag = 1 (unsaturated sum 32798). Then input -32768 -> output clamped to -32768 with sat_flag = 1.
- data_valid held high continuously with changing data:
  - Only samples present on edges where data_ready is high are accepted, one per 18 cycles.
  - The count of data_out_valid pulses equals the count of accepts.
- clear at MUL cycle 5 -> no output pulse and data_ready high the next cycle. Then input 500 -> output 500, proving x_prev and y_prev were zeroed.
- Loopback: a 12-bit ramp plus a DC offset of 2000 passes through the existing DC-removal filter into this block.
  - The reconstructed ramp tracks the high-pass input within ±4 LSB after 8 samples.
  - There is no saturation.
